// File: rtl/micro_seq_pkg.sv
// Shared constants and types for the micro-sequencer: microword layout,
// sequencing opcodes, FSM states and return-stack sizing.
package micro_seq_pkg;

   localparam int WORD_W      = 56;
   localparam int UPC_W       = 10;
   localparam int STACK_DEPTH = 4;
   localparam int SP_W        = $clog2(STACK_DEPTH + 1);  // 0..STACK_DEPTH
   localparam int IDX_W       = $clog2(STACK_DEPTH);

   // Microword field bit positions
   localparam int FLD_ALUC_HI  = 55;
   localparam int FLD_ALUC_LO  = 52;
   localparam int FLD_SELA_HI  = 51;
   localparam int FLD_SELA_LO  = 46;
   localparam int FLD_SELB_HI  = 45;
   localparam int FLD_SELB_LO  = 40;
   localparam int FLD_CSEL_HI  = 39;
   localparam int FLD_CSEL_LO  = 34;
   localparam int FLD_SHIFT_HI = 33;
   localparam int FLD_SHIFT_LO = 32;
   localparam int FLD_KMX_SEL  = 31;
   localparam int FLD_CY_SRC   = 30;
   localparam int FLD_SEQ_HI   = 29;
   localparam int FLD_SEQ_LO   = 27;
   localparam int FLD_C_WE     = 26;
   localparam int FLD_KMX_HI   = 25;
   localparam int FLD_KMX_LO   = 10;
   localparam int FLD_ADDR_HI  = 9;
   localparam int FLD_ADDR_LO  = 0;

   typedef enum logic [2:0] {
      SEQ_NEXT = 3'b000,
      SEQ_JUMP = 3'b001,
      SEQ_JZ   = 3'b010,
      SEQ_JC   = 3'b011,
      SEQ_CALL = 3'b100,
      SEQ_RET  = 3'b101,
      SEQ_WAIT = 3'b110,
      SEQ_HALT = 3'b111
   } seq_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALTED = 3'd5
   } state_e;

endpackage

// File: rtl/micro_stack.sv
// Return-address stack: STACK_DEPTH entries of UPC_W bits, LIFO.
// Push when full and pop when empty are ignored; the caller flags the error.
module micro_stack
   import micro_seq_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [UPC_W-1:0] data_i,
   output logic [UPC_W-1:0] top_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [UPC_W-1:0] mem_q [STACK_DEPTH];
   logic [SP_W-1:0]  sp_q;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] top_idx;

   assign full_o  = (sp_q == SP_W'(STACK_DEPTH));
   assign empty_o = (sp_q == '0);
   assign wr_idx  = IDX_W'(sp_q);
   assign top_idx = IDX_W'(sp_q - SP_W'(1));
   assign top_o   = mem_q[top_idx];

   // Stack pointer: cleared by reset or when the sequencer returns to idle
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         sp_q <= '0;
      end else if (push_i && !full_o) begin
         sp_q <= sp_q + SP_W'(1);
      end else if (pop_i && !empty_o) begin
         sp_q <= sp_q - SP_W'(1);
      end
   end

   // Entry storage
   // NOTE: storage has no reset; an entry is only read after a push wrote it,
   // and leaving it out lets the array map onto plain flops or a small RAM.
   always_ff @(posedge clk_i) begin
      if (push_i && !full_o) begin
         mem_q[wr_idx] <= data_i;
      end
   end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: fetches 56-bit microwords from an external
// control store, drives datapath control fields and sequences the uPC
// with branches, calls and returns. Every microinstruction takes four
// cycles: FETCH -> LOAD -> EXEC -> WB.
module micro_sequencer
   import micro_seq_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic [UPC_W-1:0]  rom_addr_o,
   input  logic [WORD_W-1:0] rom_data_i,
   input  logic [15:0]       alu_w_i,
   input  logic              alu_cy_i,
   output logic [3:0]        aluc_o,
   output logic [5:0]        sel_a_rb_o,
   output logic [5:0]        sel_b_rb_o,
   output logic [5:0]        c_sel_rb_o,
   output logic [1:0]        shifter_sel_o,
   output logic              y_x_kmx_sel_o,
   output logic [15:0]       y_kmx_in_o,
   output logic              cy_in_o,
   output logic              latch_en_o,
   output logic              regbank_we_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   state_e            state_q, state_d;
   logic [UPC_W-1:0]  upc_q, upc_d;
   logic [UPC_W-1:0]  upc_wb;
   logic [WORD_W-1:0] ir_q;
   logic              c_q, z_q, c_snap_q, err_q;

   seq_op_e           seq_op;
   logic [UPC_W-1:0]  br_addr;
   logic              seq_push, seq_pop, seq_err, seq_halt;
   logic [UPC_W-1:0]  stk_top;
   logic              stk_full, stk_empty;

   // The zero flag is kept as architectural state; no branch reads it back.
   logic unused_flags;
   assign unused_flags = z_q;

   assign seq_op  = seq_op_e'(ir_q[FLD_SEQ_HI:FLD_SEQ_LO]);
   assign br_addr = ir_q[FLD_ADDR_HI:FLD_ADDR_LO];

   // Field outputs come straight from IR, which only changes at the end of
   // LOAD, so they hold their last values outside EXEC/WB for free.
   assign aluc_o        = ir_q[FLD_ALUC_HI:FLD_ALUC_LO];
   assign sel_a_rb_o    = ir_q[FLD_SELA_HI:FLD_SELA_LO];
   assign sel_b_rb_o    = ir_q[FLD_SELB_HI:FLD_SELB_LO];
   assign c_sel_rb_o    = ir_q[FLD_CSEL_HI:FLD_CSEL_LO];
   assign shifter_sel_o = ir_q[FLD_SHIFT_HI:FLD_SHIFT_LO];
   assign y_x_kmx_sel_o = ir_q[FLD_KMX_SEL];
   assign y_kmx_in_o    = ir_q[FLD_KMX_HI:FLD_KMX_LO];
   // Carry flag is snapshotted with IR so CY_IN stays stable through WB,
   // where C itself is updated.
   assign cy_in_o       = ir_q[FLD_CY_SRC] & c_snap_q;
   assign rom_addr_o    = upc_q;
   assign err_o         = err_q;

   micro_stack u_stack (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (state_q == ST_HALTED),
      .push_i  ((state_q == ST_WB) && seq_push),
      .pop_i   ((state_q == ST_WB) && seq_pop),
      .data_i  (upc_q + UPC_W'(1)),
      .top_o   (stk_top),
      .full_o  (stk_full),
      .empty_o (stk_empty)
   );

   // State register
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_i) state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_LOAD;
         ST_LOAD:   state_d = ST_EXEC;
         ST_EXEC:   state_d = ST_WB;
         ST_WB:     state_d = (seq_err || seq_halt) ? ST_HALTED : ST_FETCH;
         ST_HALTED: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: strobes and status
   always_comb begin
      latch_en_o   = 1'b0;
      regbank_we_o = 1'b0;
      busy_o       = 1'b1;
      done_o       = 1'b0;
      case (state_q)
         ST_IDLE:   busy_o       = 1'b0;
         ST_EXEC:   latch_en_o   = 1'b1;
         ST_WB:     regbank_we_o = ir_q[FLD_C_WE];
         ST_HALTED: done_o       = 1'b1;
         default:   ;
      endcase
   end

   // Sequencing decode: branch target and stack requests evaluated on the
   // ALU result presented during WB
   always_comb begin
      upc_wb   = upc_q + UPC_W'(1);  // wraps 1023 -> 0 naturally
      seq_push = 1'b0;
      seq_pop  = 1'b0;
      seq_err  = 1'b0;
      seq_halt = 1'b0;
      case (seq_op)
         SEQ_JUMP: upc_wb = br_addr;
         SEQ_JZ:   if (alu_w_i == '0) upc_wb = br_addr;
         SEQ_JC:   if (alu_cy_i) upc_wb = br_addr;
         SEQ_CALL: begin
            if (stk_full) begin
               seq_err = 1'b1;
            end else begin
               seq_push = 1'b1;
               upc_wb   = br_addr;
            end
         end
         SEQ_RET: begin
            if (stk_empty) begin
               seq_err = 1'b1;
            end else begin
               seq_pop = 1'b1;
               upc_wb  = stk_top;
            end
         end
         SEQ_HALT: seq_halt = 1'b1;
         default:  ;  // NEXT and WAIT advance by one
      endcase
   end

   // uPC next value: advance in WB, clear on the way back to IDLE
   always_comb begin
      upc_d = upc_q;
      if (state_q == ST_WB && !seq_err && !seq_halt) upc_d = upc_wb;
      else if (state_q == ST_HALTED)                  upc_d = '0;
   end

   // Datapath registers: uPC, IR, flags and sticky error
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         upc_q    <= '0;
         ir_q     <= '0;
         c_q      <= 1'b0;
         z_q      <= 1'b0;
         c_snap_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         upc_q <= upc_d;
         if (state_q == ST_LOAD) begin
            ir_q     <= rom_data_i;
            c_snap_q <= c_q;
         end
         if (state_q == ST_WB) begin
            c_q <= alu_cy_i;
            z_q <= (alu_w_i == '0);
            if (seq_err) err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: behavioural control store with
// one-cycle read latency, a scoreboard of expected executed microwords
// (address, write strobe, carry-in) checked whenever LATCH_EN pulses, and
// directed checks on timing, flags and reset behaviour.
module tb_micro_sequencer;

   localparam logic [2:0] OP_NEXT = 3'b000;
   localparam logic [2:0] OP_JUMP = 3'b001;
   localparam logic [2:0] OP_JZ   = 3'b010;
   localparam logic [2:0] OP_JC   = 3'b011;
   localparam logic [2:0] OP_CALL = 3'b100;
   localparam logic [2:0] OP_RET  = 3'b101;
   localparam logic [2:0] OP_WAIT = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [9:0]  rom_addr;
   logic [55:0] rom_data;
   logic [15:0] alu_w;
   logic        alu_cy;
   logic [3:0]  aluc;
   logic [5:0]  sel_a, sel_b, c_sel;
   logic [1:0]  shifter_sel;
   logic        kmx_sel;
   logic [15:0] kmx;
   logic        cy_in, latch_en, regbank_we, busy, done, err;

   always #5 clk = ~clk;

   micro_sequencer dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .rom_addr_o    (rom_addr),
      .rom_data_i    (rom_data),
      .alu_w_i       (alu_w),
      .alu_cy_i      (alu_cy),
      .aluc_o        (aluc),
      .sel_a_rb_o    (sel_a),
      .sel_b_rb_o    (sel_b),
      .c_sel_rb_o    (c_sel),
      .shifter_sel_o (shifter_sel),
      .y_x_kmx_sel_o (kmx_sel),
      .y_kmx_in_o    (kmx),
      .cy_in_o       (cy_in),
      .latch_en_o    (latch_en),
      .regbank_we_o  (regbank_we),
      .busy_o        (busy),
      .done_o        (done),
      .err_o         (err)
   );

   // Control store with one cycle of read latency
   logic [55:0] rom [1024];
   always @(posedge clk) rom_data <= rom[rom_addr];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [9:0] addr;
      logic       we;
      logic       cy;
   } exp_t;
   exp_t sb[$];

   task automatic expect_exec(input logic [9:0] addr, input logic we, input logic cy);
      exp_t e;
      e.addr = addr;
      e.we   = we;
      e.cy   = cy;
      sb.push_back(e);
   endtask

   // Monitor: each EXEC cycle consumes one scoreboard entry; the write
   // strobe is checked in the following (WB) cycle.
   logic we_pending = 1'b0;
   logic we_exp     = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (we_pending) begin
         check("regbank_we_wb", 32'(regbank_we), 32'(we_exp));
         we_pending = 1'b0;
      end
      if (latch_en === 1'b1) begin
         if (sb.size() == 0) begin
            check("exec_unexpected", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("exec_addr", 32'(rom_addr), 32'(e.addr));
            check("exec_cy_in", 32'(cy_in), 32'(e.cy));
            we_exp     = e.we;
            we_pending = 1'b1;
         end
      end
   end

   function automatic logic [55:0] mk(input logic [2:0] op, input logic [9:0] addr,
                                      input logic c_we, input logic cy_src);
      logic [55:0] w;
      w        = '0;
      w[29:27] = op;
      w[9:0]   = addr;
      w[26]    = c_we;
      w[30]    = cy_src;
      return w;
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 1024; i++) rom[i] = mk(OP_HALT, 10'd0, 1'b0, 1'b0);
   endtask

   task automatic reset_dut();
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Returns at the falling edge of the first FETCH cycle
   task automatic start_prog();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", 32'(done), 32'd1);
      if (done === 1'b1) begin
         check("busy_in_halted", 32'(busy), 32'd1);
         @(negedge clk);
         check("done_one_cycle", 32'(done), 32'd0);
         check("busy_after_done", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [55:0] w;
      rst    = 1'b1;
      start  = 1'b0;
      alu_w  = 16'h0005;
      alu_cy = 1'b0;
      clear_rom();

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_latch_en", 32'(latch_en), 32'd0);
      check("rst_regbank_we", 32'(regbank_we), 32'd0);
      check("rst_fields", 32'({aluc, sel_a, sel_b, c_sel, shifter_sel, kmx_sel}), 32'd0);
      check("rst_kmx_cy", 32'({kmx, cy_in}), 32'd0);
      rst = 1'b0;

      // Basic NEXT with C_WE: four-cycle timing and field decode
      w          = mk(OP_NEXT, 10'd0, 1'b1, 1'b0);
      w[55:52]   = 4'hA;
      w[51:46]   = 6'h15;
      w[45:40]   = 6'h2A;
      w[39:34]   = 6'h33;
      w[33:32]   = 2'b10;
      w[31]      = 1'b1;
      w[25:10]   = 16'h1234;
      rom[0]     = w;
      expect_exec(10'h000, 1'b1, 1'b0);
      expect_exec(10'h001, 1'b0, 1'b0);
      start_prog();
      check("t1_fetch_addr", 32'(rom_addr), 32'd0);
      check("t1_fetch_busy", 32'(busy), 32'd1);
      check("t1_fetch_latch", 32'(latch_en), 32'd0);
      @(negedge clk);
      check("t1_load_latch", 32'(latch_en), 32'd0);
      @(negedge clk);
      check("t1_exec_latch", 32'(latch_en), 32'd1);
      check("t1_exec_we", 32'(regbank_we), 32'd0);
      check("t1_exec_fields", 32'({aluc, sel_a, sel_b, c_sel, shifter_sel, kmx_sel}),
            32'({4'hA, 6'h15, 6'h2A, 6'h33, 2'b10, 1'b1}));
      check("t1_exec_kmx", 32'(kmx), 32'h1234);
      @(negedge clk);
      check("t1_wb_latch", 32'(latch_en), 32'd0);
      @(negedge clk);
      check("t1_next_fetch_addr", 32'(rom_addr), 32'd1);
      check("t1_fetch_hold_aluc", 32'(aluc), 32'hA);
      check("t1_fetch_we", 32'(regbank_we), 32'd0);
      wait_done(32);

      // JZ taken / not taken
      clear_rom();
      rom[0] = mk(OP_JZ, 10'h155, 1'b0, 1'b0);
      alu_w  = 16'h0000;
      expect_exec(10'h000, 1'b0, 1'b0);
      expect_exec(10'h155, 1'b0, 1'b0);
      start_prog();
      wait_done(32);
      alu_w = 16'h0001;
      expect_exec(10'h000, 1'b0, 1'b0);
      expect_exec(10'h001, 1'b0, 1'b0);
      start_prog();
      wait_done(32);

      // JC to 0x3FF, NEXT wraps to 0; carry then drops so JC falls through
      clear_rom();
      rom[0]      = mk(OP_JC, 10'h3FF, 1'b0, 1'b0);
      rom[10'h3FF] = mk(OP_NEXT, 10'd0, 1'b0, 1'b0);
      alu_cy      = 1'b1;
      expect_exec(10'h000, 1'b0, 1'b0);
      expect_exec(10'h3FF, 1'b0, 1'b0);
      expect_exec(10'h000, 1'b0, 1'b0);
      expect_exec(10'h001, 1'b0, 1'b0);
      start_prog();
      repeat (8) @(negedge clk);
      alu_cy = 1'b0;
      wait_done(48);
      check("t3_err_after_wrap", 32'(err), 32'd0);

      // CY_IN uses stored carry when CY_SRC=1
      clear_rom();
      rom[0] = mk(OP_NEXT, 10'd0, 1'b0, 1'b0);
      rom[1] = mk(OP_HALT, 10'd0, 1'b0, 1'b1);
      alu_cy = 1'b1;
      expect_exec(10'h000, 1'b0, 1'b0);
      expect_exec(10'h001, 1'b0, 1'b1);
      start_prog();
      wait_done(32);
      rom[0] = mk(OP_WAIT, 10'h3C3, 1'b0, 1'b0);
      alu_cy = 1'b0;
      expect_exec(10'h000, 1'b0, 1'b0);
      expect_exec(10'h001, 1'b0, 1'b0);
      start_prog();
      wait_done(32);

      // CALL then RET, then RET on empty stack -> error
      clear_rom();
      rom[0]     = mk(OP_CALL, 10'h020, 1'b0, 1'b0);
      rom[10'h20] = mk(OP_RET, 10'd0, 1'b0, 1'b0);
      rom[1]     = mk(OP_RET, 10'd0, 1'b0, 1'b0);
      expect_exec(10'h000, 1'b0, 1'b0);
      expect_exec(10'h020, 1'b0, 1'b0);
      expect_exec(10'h001, 1'b0, 1'b0);
      start_prog();
      wait_done(48);
      check("t6_ret_empty_err", 32'(err), 32'd1);

      // Five nested CALLs overflow the stack
      reset_dut();
      check("t5_err_cleared_by_rst", 32'(err), 32'd0);
      clear_rom();
      rom[0]     = mk(OP_CALL, 10'h010, 1'b0, 1'b0);
      rom[10'h10] = mk(OP_CALL, 10'h020, 1'b0, 1'b0);
      rom[10'h20] = mk(OP_CALL, 10'h030, 1'b0, 1'b0);
      rom[10'h30] = mk(OP_CALL, 10'h040, 1'b0, 1'b0);
      rom[10'h40] = mk(OP_CALL, 10'h050, 1'b0, 1'b0);
      expect_exec(10'h000, 1'b0, 1'b0);
      expect_exec(10'h010, 1'b0, 1'b0);
      expect_exec(10'h020, 1'b0, 1'b0);
      expect_exec(10'h030, 1'b0, 1'b0);
      expect_exec(10'h040, 1'b0, 1'b0);
      start_prog();
      wait_done(64);
      check("t5_overflow_err", 32'(err), 32'd1);
      check("t5_idle_addr", 32'(rom_addr), 32'd0);
      rom[0] = mk(OP_HALT, 10'd0, 1'b0, 1'b0);
      expect_exec(10'h000, 1'b0, 1'b0);
      start_prog();
      wait_done(32);
      check("t5_err_sticky", 32'(err), 32'd1);

      // Reset during WB abandons the instruction
      reset_dut();
      clear_rom();
      rom[0] = mk(OP_NEXT, 10'd0, 1'b1, 1'b0);
      expect_exec(10'h000, 1'b1, 1'b0);
      start_prog();
      repeat (3) @(negedge clk);
      check("t7_in_wb_we", 32'(regbank_we), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("t7_rst_we", 32'(regbank_we), 32'd0);
      check("t7_rst_busy", 32'(busy), 32'd0);
      check("t7_rst_addr", 32'(rom_addr), 32'd0);
      check("t7_rst_err", 32'(err), 32'd0);
      rst = 1'b0;

      // START while busy is ignored
      rom[0] = mk(OP_JUMP, 10'h002, 1'b0, 1'b0);
      rom[2] = mk(OP_HALT, 10'd0, 1'b0, 1'b0);
      expect_exec(10'h000, 1'b0, 1'b0);
      expect_exec(10'h002, 1'b0, 1'b0);
      start_prog();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done(32);
      repeat (8) @(negedge clk);
      check("t7_idle_busy", 32'(busy), 32'd0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 CLK  in  1  single system clock; all state changes on rising edge.
REQ-002 RST  in  1  synchronous, active-high reset.
REQ-003 START  in  1  begin microprogram at address 0; sampled only in IDLE.
REQ-004 ROM_ADDR  out  10  control-store address, registered.
REQ-005 ROM_DATA  in  56  microinstruction; valid one cycle after ROM_ADDR changes.
REQ-006 ALU_W  in  16  ALU/regbank result word (W_Block1).
REQ-007 ALU_CY  in  1  ALU carry out (CY_OUT).
REQ-008 ALUC_IN  out  4; SEL_A_RB / SEL_B_RB / C_SEL_RB  out  6 each; SHIFTER_SEL  out  2; Y_X_KMX_SEL  out  1; Y_KMX_IN  out  16: datapath control fields.
REQ-009 CY_IN  out  1  carry into ALU.
REQ-010 LATCH_EN  out  1  one-cycle ALU latch strobe.
REQ-011 REGBANK_WE  out  1  one-cycle register-bank write strobe.
REQ-012 BUSY  out  1; DONE  out  1, one-cycle pulse; ERR  out  1, sticky.

Function
REQ-013 Microword fields: [55:52] ALUC, [51:46] SEL_A, [45:40] SEL_B, [39:34] C_SEL, [33:32] SHIFT, [31] KMX_SEL, [30] CY_SRC, [29:27] SEQ_OP, [26] C_WE, [25:10] KMX constant, [9:0] branch address.
REQ-014 FSM states: IDLE, FETCH, LOAD, EXEC, WB, HALTED. Each microinstruction takes exactly 4 cycles: FETCH->LOAD->EXEC->WB.
REQ-015 IDLE: uPC=0, ROM_ADDR=0, BUSY=0. START=1 -> FETCH.
REQ-016 FETCH: ROM_ADDR=uPC. LOAD: IR<=ROM_DATA.
REQ-017 EXEC and WB: field outputs driven from IR. LATCH_EN=1 in EXEC only.
REQ-018 WB: REGBANK_WE=IR.C_WE. Carry flag C<=ALU_CY. Zero flag Z<=(ALU_W==0). Next uPC computed from ALU_CY and ALU_W sampled in this cycle. Next state FETCH unless stated otherwise.
REQ-019 CY_IN = 0 when CY_SRC=0; otherwise the stored C flag.
REQ-020 SEQ_OP: 000 NEXT uPC+1; 001 JUMP addr; 010 JZ addr if zero else +1; 011 JC addr if carry else +1; 100 CALL push uPC+1, jump addr; 101 RET pop; 110 NOP-wait (uPC+1, ignored flags); 111 HALT.
REQ-021 uPC+1 wraps 1023->0 with no error.
REQ-022 Return stack: 4 entries of 10 bits, LIFO.
REQ-023 CALL with 4 entries full: ERR=1, no push, -> HALTED.
REQ-024 RET with stack empty: ERR=1, -> HALTED.
REQ-025 HALT in WB -> HALTED. In HALTED, DONE=1 for exactly one cycle, then -> IDLE.
REQ-026 START outside IDLE is ignored. Entering IDLE clears the stack pointer; ERR is not cleared.
REQ-027 Outside EXEC/WB, all field outputs hold their last values. LATCH_EN=REGBANK_WE=0.
REQ-028 BUSY=1 in FETCH, LOAD, EXEC, WB and HALTED.

Reset
REQ-029 RST=1 at a clock edge: state=IDLE; uPC, IR, stack pointer, C, Z, ERR = 0; all outputs = 0.
REQ-030 Reset mid-instruction, including WB, abandons it. REGBANK_WE is 0 from the same edge.

Structure
REQ-031 Package micro_seq_pkg holds: microword field bit positions, SEQ_OP encodings, state enum, STACK_DEPTH=4, UPC_W=10, WORD_W=56.
REQ-032 Return stack is a sub-module micro_stack with push/pop/full/empty ports. Everything else is in micro_sequencer.

Verification
REQ-033 Reset, then START; ROM[0]=NEXT, C_WE=1 -> ROM_ADDR=0 in FETCH, LATCH_EN 3rd cycle, REGBANK_WE 4th cycle, ROM_ADDR=1 at next FETCH.
REQ-034 ROM[0]=JZ 0x155, ALU_W=0 in WB -> next ROM_ADDR=0x155. Repeat with ALU_W=0x0001 -> ROM_ADDR=1.
REQ-035 ROM[0]=JC 0x3FF with ALU_CY=1; ROM[0x3FF]=NEXT -> then ROM_ADDR=0 (wrap), ERR=0. ROM[1] with CY_SRC=1 -> CY_IN=1.
REQ-036 Five nested CALLs -> fifth sets ERR=1, DONE pulses once, BUSY=0 after. START again: ERR stays 1.
REQ-037 CALL 0x020 at 0, RET at 0x020 -> ROM_ADDR=1 next. A subsequent RET at 1 -> ERR=1 and HALTED.
REQ-038 RST asserted during WB with C_WE=1 -> REGBANK_WE=0 at that edge, state IDLE, uPC=0. START while BUSY has no effect.
